and3_self_test: RTL and testbench

- Stimulus/checker end of the 3-input AND interface (a, b, c -> d).
- Drives all 8 input combinations onto a, b, c and samples the returned d after a programmable settle time.
- Compares each sample against a&b&c and reports the per-vector failures, an error count, and a pass flag.
- Sits beside the AND datapath as a built-in self-test; its a/b/c outputs feed the gate inputs and its d input takes the gate output.

---
 rtl/and3_self_test.sv | 169 ++++++++++++++++
 tb/tb_and3_self_test.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/and3_self_test.sv
// Built-in self-test for a 3-input AND gate: walks all eight a/b/c vectors, checks d, reports results.
// Optional macro AND3_SELF_TEST_LOOP_EN adds a 'loop' input that re-runs the sweep and accumulates errors.
module and3_self_test #(
    parameter int WAIT_CYCLES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef AND3_SELF_TEST_LOOP_EN
    input  logic             loop,
`endif
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       fail_vec
);

    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [2:0]         vec_r, vec_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [ERR_W-1:0]   err_r, err_s;
    logic [7:0]         fail_r, fail_s;
    logic               pass_r, pass_s;
    logic               done_r, done_s;
    logic               busy_r, busy_s;
    logic [2:0]         abc_r, abc_s;
    logic               loop_s;

    function automatic logic and3_expected(input logic [2:0] v);
        return v[2] & v[1] & v[0];
    endfunction

`ifdef AND3_SELF_TEST_LOOP_EN
    assign loop_s = loop;
`else
    assign loop_s = 1'b0;
`endif

    // Next-state and next-output logic; outputs are derived from the next state so they come out registered.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        fail_s  = fail_r;
        pass_s  = pass_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_DRIVE;
                    vec_s   = 3'd0;
                    err_s   = {ERR_W{1'b0}};
                    fail_s  = 8'h00;
                    pass_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (WAIT_CYCLES == 0) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_s = ST_CHECK;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (d != and3_expected(vec_r)) begin
                    fail_s[vec_r] = 1'b1;
                    if (err_r != ERR_MAX) begin
                        err_s = err_r + ERR_W'(1);
                    end else begin
                        err_s = err_r;
                    end
                end else begin
                    fail_s = fail_r;
                end
                if (vec_r == 3'd7) begin
                    state_s = ST_DONE;
                end else begin
                    vec_s   = vec_r + 3'd1;
                    state_s = ST_DRIVE;
                end
            end
            ST_DONE: begin
                pass_s = (err_r == {ERR_W{1'b0}});
                if (loop_s) begin
                    state_s = ST_DRIVE;
                    vec_s   = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        done_s = (state_s == ST_DONE);
        busy_s = (state_s == ST_DRIVE) || (state_s == ST_WAIT) || (state_s == ST_CHECK);
        // Stimulus is parked at zero whenever the checker is idle.
        if (state_s == ST_IDLE) begin
            abc_s = 3'd0;
        end else begin
            abc_s = vec_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            vec_r   <= 3'd0;
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= {ERR_W{1'b0}};
            fail_r  <= 8'h00;
            pass_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            abc_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            fail_r  <= fail_s;
            pass_r  <= pass_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            abc_r   <= abc_s;
        end
    end

    assign a        = abc_r[2];
    assign b        = abc_r[1];
    assign c        = abc_r[0];
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_cnt  = err_r;
    assign fail_vec = fail_r;

endmodule

// File: tb/tb_and3_self_test.sv
// Scoreboard bench for and3_self_test: one default instance and one with WAIT_CYCLES=0, each with a modelled gate.
module tb_and3_self_test;

    typedef struct {
        int         err;
        logic [7:0] fail;
        logic       pass;
        int         done_n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst0, rst1, start0, start1, loop1;
    logic       a0, b0, c0, d0, busy0, done0, pass0;
    logic       a1, b1, c1, d1, busy1, done1, pass1;
    logic [7:0] err0, fail0, err1, fail1;
    int         mode0, mode1;
    int         tests_run    = 0;
    int         tests_failed = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    // Gate models: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 ignores c.
    function automatic logic gate_out(input int mode, input logic [2:0] v);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return v[2] & v[1];
            default: return v[2] & v[1] & v[0];
        endcase
    endfunction

    assign d0 = gate_out(mode0, {a0, b0, c0});
    assign d1 = gate_out(mode1, {a1, b1, c1});

    and3_self_test u_dut0 (
        .clk(clk), .rst(rst0), .start(start0),
`ifdef AND3_SELF_TEST_LOOP_EN
        .loop(1'b0),
`endif
        .a(a0), .b(b0), .c(c0), .d(d0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fail0)
    );

    and3_self_test #(.WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1),
`ifdef AND3_SELF_TEST_LOOP_EN
        .loop(loop1),
`endif
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fail1)
    );

    function automatic exp_t model(input int mode, input int wait_c, input int err_in, input logic [7:0] fail_in);
        exp_t e;
        e.err  = err_in;
        e.fail = fail_in;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vb;
            vb = 3'(v);
            if (gate_out(mode, vb) != (vb[2] & vb[1] & vb[0])) begin
                e.fail[v] = 1'b1;
                if (e.err < 255) e.err++;
            end
        end
        e.pass   = (e.err == 0);
        e.done_n = 8 * (2 + wait_c);
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full sweep on the default instance; checks stimulus sequence, done timing and results.
    task automatic run0(input int mode);
        exp_t e;
        int   done_n  = -1;
        int   ndone   = 0;
        int   seq_bad = 0;
        mode0 = mode;
        sb.push_back(model(mode, 2, 0, 8'h00));
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        for (int n = 0; n < 45; n++) begin
            if (n < 32) begin
                if ({a0, b0, c0} !== 3'(n / 4) || busy0 !== 1'b1) seq_bad++;
            end
            if (done0 === 1'b1) begin
                ndone++;
                if (done_n < 0) done_n = n;
            end
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        check_val($sformatf("m%0d_seq", mode), seq_bad, 0);
        check_val($sformatf("m%0d_done_cnt", mode), ndone, 1);
        check_val($sformatf("m%0d_done_at", mode), done_n, e.done_n);
        check_val($sformatf("m%0d_err", mode), err0, e.err);
        check_val($sformatf("m%0d_fail", mode), fail0, e.fail);
        check_val($sformatf("m%0d_pass", mode), pass0, e.pass);
        check_val($sformatf("m%0d_idle", mode), {a0, b0, c0, busy0}, 4'h0);
    endtask

    initial begin
        exp_t e;
        int   ndone;
        int   first_n;
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0; loop1 = 1'b0;
        mode0 = 0; mode1 = 1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_outs", {a0, b0, c0, busy0, done0, pass0}, 6'h00);
        check_val("rst_err", err0, 8'h00);
        check_val("rst_fail", fail0, 8'h00);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;

        run0(0);
        run0(1);
        run0(2);
        run0(3);

        // Abort during vector 3 wait with a stuck-at-1 gate.
        mode0 = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        check_val("pre_rst_err", err0, 8'd3);
        @(negedge clk);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        check_val("abort_outs", {a0, b0, c0, busy0, done0}, 5'h00);
        check_val("abort_err", err0, 8'h00);
        check_val("abort_fail", fail0, 8'h00);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            if (done0 === 1'b1) ndone++;
            @(posedge clk);
            #1;
        end
        check_val("abort_no_done", ndone, 0);
        run0(0);

        // WAIT_CYCLES=0, stuck-at-0, start held for 40 cycles: two back-to-back runs.
        mode1 = 1;
        sb.push_back(model(1, 0, 0, 8'h00));
        sb.push_back(model(1, 0, 0, 8'h00));
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        ndone   = 0;
        first_n = -1;
        for (int n = 0; n < 40; n++) begin
            if (done1 === 1'b1) begin
                ndone++;
                if (first_n < 0) begin
                    first_n = n;
                    check_val("held_busy_in_done", busy1, 1'b0);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_val($sformatf("held_err_run%0d", ndone), err1, e.err);
                    check_val($sformatf("held_fail_run%0d", ndone), fail1, e.fail);
                end
            end
            if (n == 19) check_val("held_restart_clears", err1, 8'h00);
            if (n == 36) check_val("held_pass", pass1, 1'b0);
            @(posedge clk);
            #1;
        end
        start1 = 1'b0;
        check_val("held_first_done", first_n, 16);
        check_val("held_done_cnt", ndone, 2);
        repeat (25) @(posedge clk);
        #1;

`ifdef AND3_SELF_TEST_LOOP_EN
        // Loop mode: errors accumulate across passes.
        e = model(1, 0, 0, 8'h00);
        sb.push_back(e);
        sb.push_back(model(1, 0, e.err, e.fail));
        loop1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        ndone  = 0;
        for (int n = 0; n < 60; n++) begin
            if (done1 === 1'b1) begin
                ndone++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_val($sformatf("loop_err_pass%0d", ndone), err1, e.err);
                    check_val($sformatf("loop_fail_pass%0d", ndone), fail1, e.fail);
                end
                if (ndone == 2) loop1 = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check_val("loop_done_cnt", ndone, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
